interleaver_prime_stream: RTL and testbench

- Streaming, sample-serial successor to the combinational prime interleaver.
- Accepts one BITS-wide sample per cycle and buffers N+TAIL_BITS samples per block in a ping-pong RAM pair.
- Emits each block permuted by i -> (P*i) mod N. Tail samples pass through unpermuted.
- Per-block forward/reverse mode. Sits between the constituent encoders/decoders and the SISO stages of the turbo chain.

---
 rtl/interleaver_prime_stream.sv | 226 ++++++++++++++++++++++
 tb/tb_interleaver_prime_stream.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/interleaver_prime_stream.sv
// interleaver_prime_stream
//   Streaming prime interleaver. Takes one BITS-wide sample per cycle and
//   buffers N+TAIL_BITS samples per block in a ping-pong RAM pair. Each block
//   is emitted permuted by i -> (P*i) mod N. Tail samples pass through in
//   natural order. The mode is chosen per block (0 = forward, 1 = reverse).
//   A bank is handed back to the writer as soon as its last word has been
//   read into the output register. This keeps both sides at one sample per
//   cycle despite the two-cycle read latency.
//   Optional: define INTERLEAVER_BLOCK_COUNT_EN to add the block_count output,
//   a 16-bit count of completed output blocks.
module interleaver_prime_stream #(
  parameter int BITS      = 8,
  parameter int N         = 10,
  parameter int P         = 3,
  parameter int TAIL_BITS = 0
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [BITS-1:0] in_data,
  input  logic            in_reverse,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [BITS-1:0] out_data,
  output logic            out_last,
  output logic            out_reverse
`ifdef INTERLEAVER_BLOCK_COUNT_EN
  ,
  output logic [15:0]     block_count
`endif
);

  localparam int L  = N + TAIL_BITS;
  localparam int CW = $clog2(L + 1);
  localparam int AW = (L > 1) ? $clog2(L) : 1;
  localparam logic [CW-1:0] N_W    = CW'(N);
  localparam logic [CW-1:0] P_W    = CW'(P);
  localparam logic [CW-1:0] LAST_W = CW'(L - 1);

  function automatic int gcd(input int a, input int b);
    int x, y, t;
    x = a;
    y = b;
    while (y != 0) begin
      t = x % y;
      x = y;
      y = t;
    end
    return x;
  endfunction

  if (P <= 0 || P >= N || gcd(N, P) != 1) begin : g_bad_p
    $error("interleaver_prime_stream: P=%0d must satisfy 0<P<N and gcd(N,P)=1 (N=%0d)", P, N);
  end

  // Next permuted address: pa + P, wrapped into 0..N-1 without a multiplier.
  function automatic logic [CW-1:0] pa_step(input logic [CW-1:0] pa);
    logic [CW:0] sum;
    sum = {1'b0, pa} + {1'b0, P_W};
    if (sum >= {1'b0, N_W}) sum = sum - {1'b0, N_W};
    return sum[CW-1:0];
  endfunction

  typedef enum logic {WR_FILL, WR_WAIT} wr_state_e;
  typedef enum logic {RD_IDLE, RD_RUN}  rd_state_e;

  logic [BITS-1:0] r_mem [2][L];
  logic [1:0]      r_full;
  logic [1:0]      r_mode;

  wr_state_e       r_wr_state, w_wr_state_next;
  logic            r_wr_bank;
  logic [CW-1:0]   r_wr_cnt, r_wr_pa;
  rd_state_e       r_rd_state, w_rd_state_next;
  logic            r_rd_bank;
  logic [CW-1:0]   r_rd_cnt, r_rd_pa;

  logic            r_out_valid, r_out_last, r_out_rev;
  logic [BITS-1:0] r_out_data;

  logic            w_wr_fire, w_wr_last, w_wr_tail, w_wr_rev, w_wr_free, w_new_busy;
  logic [AW-1:0]   w_wr_addr;
  logic            w_rd_issue, w_rd_last, w_rd_tail, w_rd_release;
  logic [AW-1:0]   w_rd_addr;

  // Write-side address generation.
  // A bank is writable when it is empty or is being released in this same cycle.
  assign w_rd_release = w_rd_issue && w_rd_last;
  assign w_wr_free    = !r_full[r_wr_bank] || (w_rd_release && (r_rd_bank == r_wr_bank));
  assign in_ready     = reset_n && w_wr_free;
  assign w_wr_fire    = in_valid && in_ready;
  assign w_wr_last    = (r_wr_cnt == LAST_W);
  assign w_wr_tail    = (r_wr_cnt >= N_W);
  assign w_wr_rev     = (r_wr_cnt == '0) ? in_reverse : r_mode[r_wr_bank];
  assign w_wr_addr    = (w_wr_rev && !w_wr_tail) ? AW'(r_wr_pa) : AW'(r_wr_cnt);
  assign w_new_busy   = r_full[!r_wr_bank] && !(w_rd_release && (r_rd_bank == !r_wr_bank));

  // Read-side address generation.
  assign w_rd_last    = (r_rd_cnt == LAST_W);
  assign w_rd_tail    = (r_rd_cnt >= N_W);
  assign w_rd_addr    = (!r_mode[r_rd_bank] && !w_rd_tail) ? AW'(r_rd_pa) : AW'(r_rd_cnt);

  // Write FSM next state: park in WR_WAIT while the next bank is still occupied.
  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    w_wr_state_next = r_wr_state;
    case (r_wr_state)
      WR_FILL: if (w_wr_fire && w_wr_last && w_new_busy) w_wr_state_next = WR_WAIT;
      WR_WAIT: if (w_wr_free) w_wr_state_next = WR_FILL;
      default: w_wr_state_next = WR_FILL;
    endcase
  end

  // Read FSM next state and read issue. Issue only into a free or draining output register.
  always_comb begin
    w_rd_state_next = r_rd_state;
    w_rd_issue      = 1'b0;
    case (r_rd_state)
      RD_IDLE: if (r_full[r_rd_bank]) w_rd_state_next = RD_RUN;
      RD_RUN: begin
        w_rd_issue = r_full[r_rd_bank] && (!r_out_valid || out_ready);
        if (!r_full[r_rd_bank] && (!r_out_valid || out_ready)) w_rd_state_next = RD_IDLE;
      end
      default: w_rd_state_next = RD_IDLE;
    endcase
  end

  // Sample storage. Only written, never reset.
  always_ff @(posedge clk) begin
    // NOTE: the RAM banks have no reset; the full flags alone define which contents are valid.
    if (w_wr_fire) r_mem[r_wr_bank][w_wr_addr] <= in_data;
  end

  // Per-bank full flags and mode bits. A release and a set in the same cycle never hit one bank.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_full <= '0;
      r_mode <= '0;
    end else begin
      if (w_rd_release) r_full[r_rd_bank] <= 1'b0;
      if (w_wr_fire && w_wr_last) r_full[r_wr_bank] <= 1'b1;
      if (w_wr_fire && (r_wr_cnt == '0)) r_mode[r_wr_bank] <= in_reverse;
    end
  end

  // Write state, bank and counters.
  always_ff @(posedge clk or negedge reset_n) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!reset_n) begin
      r_wr_state <= WR_FILL;
      r_wr_bank  <= 1'b0;
      r_wr_cnt   <= '0;
      r_wr_pa    <= '0;
    end else begin
      r_wr_state <= w_wr_state_next;
      if (w_wr_fire) begin
        if (w_wr_last) begin
          r_wr_cnt  <= '0;
          r_wr_pa   <= '0;
          r_wr_bank <= !r_wr_bank;
        end else begin
          r_wr_cnt <= r_wr_cnt + CW'(1);
          if (!w_wr_tail) r_wr_pa <= pa_step(r_wr_pa);
        end
      end
    end
  end

  // Read state, bank and counters.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rd_state <= RD_IDLE;
      r_rd_bank  <= 1'b0;
      r_rd_cnt   <= '0;
      r_rd_pa    <= '0;
    end else begin
      r_rd_state <= w_rd_state_next;
      if (w_rd_issue) begin
        if (w_rd_last) begin
          r_rd_cnt  <= '0;
          r_rd_pa   <= '0;
          r_rd_bank <= !r_rd_bank;
        end else begin
          r_rd_cnt <= r_rd_cnt + CW'(1);
          if (!w_rd_tail) r_rd_pa <= pa_step(r_rd_pa);
        end
      end
    end
  end

  // Output register. Holds its contents while stalled, loads on each read issue.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_last  <= 1'b0;
      r_out_rev   <= 1'b0;
    end else if (w_rd_issue) begin
      r_out_valid <= 1'b1;
      r_out_data  <= r_mem[r_rd_bank][w_rd_addr];
      r_out_last  <= w_rd_last;
      r_out_rev   <= r_mode[r_rd_bank];
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid   = r_out_valid;
  assign out_data    = r_out_data;
  assign out_last    = r_out_last;
  assign out_reverse = r_out_rev;

`ifdef INTERLEAVER_BLOCK_COUNT_EN
  logic [15:0] r_block_count;

  // Count blocks whose final sample was accepted downstream. Wraps naturally.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_block_count <= '0;
    else if (r_out_valid && out_ready && r_out_last) r_block_count <= r_block_count + 16'd1;
  end

  assign block_count = r_block_count;
`endif

endmodule

// File: tb/tb_interleaver_prime_stream.sv
// Directed bench for interleaver_prime_stream: reset state, forward/reverse
// blocks back to back, read latency, backpressure, mid-block reset and a
// second instance with two tail samples.
module tb_interleaver_prime_stream;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       in_valid, in_ready, in_reverse;
  logic [7:0] in_data;
  logic       out_valid, out_ready, out_last, out_reverse;
  logic [7:0] out_data;

  logic       t_in_valid, t_in_ready;
  logic [7:0] t_in_data;
  logic       t_out_valid, t_out_last, t_out_reverse;
  logic [7:0] t_out_data;
  logic       t_out_ready;

`ifdef INTERLEAVER_BLOCK_COUNT_EN
  logic [15:0] block_count, t_block_count;
`endif

  always #5 clk = ~clk;

  interleaver_prime_stream #(.BITS(8), .N(10), .P(3), .TAIL_BITS(0)) u_dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .in_reverse  (in_reverse),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_last    (out_last),
    .out_reverse (out_reverse)
`ifdef INTERLEAVER_BLOCK_COUNT_EN
    , .block_count (block_count)
`endif
  );

  interleaver_prime_stream #(.BITS(8), .N(10), .P(3), .TAIL_BITS(2)) u_tail (
    .clk         (clk),
    .reset_n     (reset_n),
    .in_valid    (t_in_valid),
    .in_ready    (t_in_ready),
    .in_data     (t_in_data),
    .in_reverse  (1'b0),
    .out_valid   (t_out_valid),
    .out_ready   (t_out_ready),
    .out_data    (t_out_data),
    .out_last    (t_out_last),
    .out_reverse (t_out_reverse)
`ifdef INTERLEAVER_BLOCK_COUNT_EN
    , .block_count (t_block_count)
`endif
  );

  typedef struct {
    logic [7:0] din;
    logic       rev;
    logic [7:0] exp_data;
    logic       exp_last;
    logic       exp_rev;
  } vec_t;

  typedef struct {
    logic [7:0] d;
    logic       l;
    logic       r;
    int         cyc;
  } obs_t;

  vec_t tbl [30];
  int   perm [10];
  obs_t got [$];
  obs_t tgot [$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   n_drop  = 0;
  int   cyc     = 0;
  bit   mon_en  = 1'b0;
  bit   drop_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Output and input-stall monitor, sampled mid-low-phase.
  always begin
    obs_t o;
    @(negedge clk);
    #1;
    if (mon_en && out_valid && out_ready) begin
      o.d = out_data; o.l = out_last; o.r = out_reverse; o.cyc = cyc;
      got.push_back(o);
    end
    if (drop_en && in_valid && !in_ready) n_drop++;
    if (t_out_valid && t_out_ready) begin
      o.d = t_out_data; o.l = t_out_last; o.r = t_out_reverse; o.cyc = cyc;
      tgot.push_back(o);
    end
  end

  task automatic send(input logic [7:0] d, input logic rev);
    int b;
    b = 0;
    in_valid = 1'b1; in_data = d; in_reverse = rev;
    #1;
    while (!in_ready && b < 100) begin @(negedge clk); #1; b++; end
    if (!in_ready) begin
      n_tests++; n_fail++;
      $display("FAIL send_timeout: in_ready=%0b, expected 1", in_ready);
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic send_t(input logic [7:0] d);
    int b;
    b = 0;
    t_in_valid = 1'b1; t_in_data = d;
    #1;
    while (!t_in_ready && b < 100) begin @(negedge clk); #1; b++; end
    if (!t_in_ready) begin
      n_tests++; n_fail++;
      $display("FAIL send_t_timeout: t_in_ready=%0b, expected 1", t_in_ready);
    end
    @(negedge clk);
    t_in_valid = 1'b0;
  endtask

  task automatic wait_got(input int n);
    int b;
    b = 0;
    while (got.size() < n && b < 300) begin @(negedge clk); #2; b++; end
    repeat (3) @(negedge clk);
    #2;
    check($sformatf("count_%0d", n), got.size(), n);
  endtask

  task automatic cmp_block(input string name, input int base);
    for (int i = 0; i < 10; i++) begin
      if (i < got.size())
        check($sformatf("%s_%0d", name, i), {got[i].d, got[i].l, got[i].r},
              {tbl[base+i].exp_data, tbl[base+i].exp_last, tbl[base+i].exp_rev});
    end
  endtask

  initial begin
    int pv [10];
    pv = '{0, 3, 6, 9, 2, 5, 8, 1, 4, 7};
    for (int i = 0; i < 10; i++) perm[i] = pv[i];
    for (int i = 0; i < 10; i++) begin
      tbl[i]    = '{din: 8'(i),           rev: 1'b0, exp_data: 8'(perm[i]),        exp_last: (i == 9), exp_rev: 1'b0};
      tbl[10+i] = '{din: 8'(perm[i]),     rev: 1'b1, exp_data: 8'(i),              exp_last: (i == 9), exp_rev: 1'b1};
      tbl[20+i] = '{din: 8'(8'hA0 + i),   rev: 1'b0, exp_data: 8'(8'hA0 + perm[i]), exp_last: (i == 9), exp_rev: 1'b0};
    end

    in_valid = 1'b0; in_data = '0; in_reverse = 1'b0; out_ready = 1'b1;
    t_in_valid = 1'b0; t_in_data = '0; t_out_ready = 1'b1;
    reset_n = 1'b0;

    // Reset state.
    repeat (2) @(negedge clk);
    #1;
    check("reset_outputs", {in_ready, out_valid, out_last, out_reverse, out_data}, 32'h0);
    check("reset_tail_in_ready", t_in_ready, 1'b0);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    check("release_in_ready", in_ready, 1'b1);

    // Three back-to-back blocks (fwd, rev, fwd) with continuous out_ready.
    @(negedge clk);
    got.delete(); mon_en = 1'b1; drop_en = 1'b1; n_drop = 0;
    for (int i = 0; i < 30; i++) send(tbl[i].din, tbl[i].rev);
    drop_en = 1'b0;
    wait_got(30);
    for (int i = 0; i < 30; i++) begin
      if (i < got.size())
        check($sformatf("steady_%0d", i), {got[i].d, got[i].l, got[i].r},
              {tbl[i].exp_data, tbl[i].exp_last, tbl[i].exp_rev});
    end
    check("steady_in_ready_drops", n_drop, 0);
    if (got.size() >= 30) check("steady_contiguous", got[29].cyc - got[0].cyc, 29);

    // Read latency from an idle read bank.
    got.delete();
    for (int i = 0; i < 10; i++) send(tbl[i].din, 1'b0);
    #1;
    check("lat_edge0", out_valid, 1'b0);
    @(negedge clk); #1;
    check("lat_edge1", out_valid, 1'b0);
    @(negedge clk); #1;
    check("lat_edge2", out_valid, 1'b1);
    wait_got(10);
    cmp_block("lat", 0);

    // Backpressure: two blocks fill both banks, output frozen, then drain.
    got.delete();
    out_ready = 1'b0;
    for (int i = 0; i < 10; i++) send(8'(8'h10 + i), 1'b0);
    for (int i = 0; i < 10; i++) send(8'(8'h20 + perm[i]), 1'b1);
    repeat (2) @(negedge clk);
    #1;
    check("stall_in_ready", in_ready, 1'b0);
    in_valid = 1'b1; in_data = 8'h55; in_reverse = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk); #1;
      check($sformatf("stall_frozen_%0d", k), {in_ready, out_valid, out_last, out_reverse, out_data},
            {1'b0, 1'b1, 1'b0, 1'b0, 8'h10});
    end
    in_valid = 1'b0;
    for (int k = 0; k < 100 && got.size() < 20; k++) begin
      @(negedge clk);
      out_ready = (k % 3 != 2);
      #2;
    end
    @(negedge clk);
    out_ready = 1'b1;
    wait_got(20);
    for (int i = 0; i < 20; i++) begin
      if (i < got.size())
        check($sformatf("drain_%0d", i), {got[i].d, got[i].l, got[i].r},
              (i < 10) ? {8'(8'h10 + perm[i]), (i == 9), 1'b0} : {8'(8'h20 + i - 10), (i == 19), 1'b1});
    end

    // Mid-block reset with a stalled output, then a clean block.
    got.delete();
    out_ready = 1'b0;
    for (int i = 0; i < 10; i++) send(8'(8'h30 + i), 1'b0);
    for (int i = 0; i < 5; i++) send(8'(8'h40 + i), 1'b1);
    @(negedge clk); #1;
    check("pre_reset_out", {out_valid, out_data}, {1'b1, 8'h30});
    #1 reset_n = 1'b0;
    #1;
    check("async_reset_outputs", {in_ready, out_valid, out_last, out_reverse, out_data}, 32'h0);
    @(negedge clk);
    reset_n = 1'b1; out_ready = 1'b1;
    #1;
    check("reset2_in_ready", in_ready, 1'b1);
    for (int i = 0; i < 10; i++) send(tbl[i].din, 1'b0);
    wait_got(10);
    cmp_block("post_reset", 0);
`ifdef INTERLEAVER_BLOCK_COUNT_EN
    check("block_count_after_reset", block_count, 16'd1);
`endif

    // Tail instance: 10 permuted samples followed by 2 natural-order tail samples.
    tgot.delete();
    for (int i = 0; i < 12; i++) send_t(8'(i));
    for (int b = 0; b < 100 && tgot.size() < 12; b++) begin @(negedge clk); #2; end
    repeat (3) @(negedge clk);
    check("tail_count", tgot.size(), 12);
    for (int i = 0; i < 12; i++) begin
      if (i < tgot.size())
        check($sformatf("tail_%0d", i), {tgot[i].d, tgot[i].l, tgot[i].r},
              {8'((i < 10) ? perm[i] : i), (i == 11), 1'b0});
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
